// File: rtl/ps2_pkg.sv
// Shared PS/2 host-side definitions: FSM states, default timings and frame edge positions.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_RTS      = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAIT_BUS = 3'd5
  } ps2_state_e;

  // 100 us inhibit and 15 ms device response window at 50 MHz.
  localparam int unsigned PS2_INHIBIT_CYCLES_DEF = 5000;
  localparam int unsigned PS2_TIMEOUT_CYCLES_DEF = 750000;

  localparam logic [3:0] EDGE_PARITY = 4'd9;
  localparam logic [3:0] EDGE_STOP   = 4'd10;
  localparam logic [3:0] EDGE_ACK    = 4'd11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 line with registered previous level for falling-edge detect.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle PS/2 lines are high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift 8 data + parity + stop, check ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic c_lvl, c_fall;
  logic d_lvl;

  ps2_sync_edge u_sync_c (
    .clk     (clk),
    .rst_n   (resetn),
    .line_i  (ps2c_in),
    .level_o (c_lvl),
    .fall_o  (c_fall)
  );

  ps2_sync_edge u_sync_d (
    .clk     (clk),
    .rst_n   (resetn),
    .line_i  (ps2d_in),
    .level_o (d_lvl),
    .fall_o  ()
  );

  ps2_state_e       state_q, state_d;
  logic [7:0]       data_q,  data_d;
  logic             par_q,   par_d;
  logic [3:0]       edge_q,  edge_d;
  logic [INH_W-1:0] inh_q,   inh_d;
  logic [TMO_W-1:0] tmo_q,   tmo_d;
  logic             dout_q,  dout_d;
  logic             done_q,  done_d;
  logic             err_q,   err_d;

  logic       tmo_hit;
  logic [3:0] edge_nxt;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    par_d    = par_q;
    edge_d   = edge_q;
    inh_d    = inh_q;
    tmo_d    = tmo_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tmo_hit  = (tmo_q >= TMO_LAST);
    edge_nxt = edge_q + 4'd1;

    // Once clocked states are entered the timeout counter runs (saturating).
    if (state_q == ST_SHIFT || state_q == ST_ACK || state_q == ST_WAIT_BUS) begin
      if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = tx_data;
          par_d   = odd_parity(tx_data);
          edge_d  = '0;
          inh_d   = '0;
          state_d = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (inh_q == INH_LAST) state_d = ST_RTS;
        else                   inh_d   = inh_q + 1'b1;
      end

      ST_RTS: begin
        tmo_d   = '0;
        dout_d  = 1'b1;
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (tmo_hit) begin
          err_d   = 1'b1;
          dout_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (c_fall) begin
          edge_d = edge_nxt;
          if (edge_nxt == EDGE_STOP) begin
            dout_d  = 1'b0;
            state_d = ST_ACK;
          end else if (edge_nxt == EDGE_PARITY) begin
            dout_d = ~par_q;
          end else begin
            dout_d = ~data_q[edge_q[2:0]];
          end
        end
      end

      ST_ACK: begin
        if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (c_fall) begin
          edge_d = EDGE_ACK;
          if (!d_lvl) begin
            state_d = ST_WAIT_BUS;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_WAIT_BUS: begin
        if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (c_lvl && d_lvl) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      par_q   <= 1'b0;
      edge_q  <= '0;
      inh_q   <= '0;
      tmo_q   <= '0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      par_q   <= par_d;
      edge_q  <= edge_d;
      inh_q   <= inh_d;
      tmo_q   <= tmo_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Line drives decode straight from state so an asynchronous reset releases the bus immediately.
  assign ps2c_oe = (state_q == ST_INHIBIT);
  assign ps2d_oe = ((state_q == ST_INHIBIT) && (inh_q == INH_LAST)) ||
                   (state_q == ST_RTS) ||
                   ((state_q == ST_SHIFT) && dout_q);
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign error   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard model and frame reference.
module tb_ps2_host_tx;

  localparam int unsigned INH = 100;
  localparam int unsigned TMO = 2000;
  localparam int          HP  = 20;

  logic       clk     = 1'b0;
  logic       resetn  = 1'b0;
  logic       start   = 1'b0;
  logic [7:0] tx_data = '0;
  logic       dev_c   = 1'b1;
  logic       dev_d   = 1'b1;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, busy, done, error;

  assign ps2c_in = dev_c & ~ps2c_oe;
  assign ps2d_in = dev_d & ~ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .tx_data (tx_data),
    .ps2c_in (ps2c_in),
    .ps2d_in (ps2d_in),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic tb_check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  int done_cnt = 0, err_cnt = 0, both_cnt = 0, busy_on_err = 0;
  int inh_run = 0, inh_len = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) begin
      err_cnt++;
      if (busy) busy_on_err++;
    end
    if (done && error) both_cnt++;
    if (ps2c_oe) inh_run++;
    else if (inh_run != 0) begin
      inh_len = inh_run;
      inh_run = 0;
    end
  end

  // Expected line levels sampled by the device after falling edges 1..10.
  function automatic logic [9:0] exp_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ((ones % 2) == 0), d};
  endfunction

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    tx_data = 8'($urandom);
    tb_check("busy_after_start", busy, 1);
  endtask

  task automatic wait_rts(output bit seen);
    int t = 0;
    seen = 1'b0;
    while (!(ps2d_oe && !ps2c_oe)) begin
      @(negedge clk);
      t++;
      if (t > 4 * INH) begin
        tb_check("rts_seen", 0, 1);
        return;
      end
    end
    seen = 1'b1;
  endtask

  task automatic run_device(input bit ack, input int poke_edge, input int reset_edge,
                            output logic [9:0] got, output bit ok);
    bit seen;
    got = '0;
    ok  = 1'b0;
    dev_c = 1'b1;
    dev_d = 1'b1;
    wait_rts(seen);
    if (!seen) return;
    tb_check("start_bit_low", ps2d_in, 0);
    repeat (HP) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      dev_c = 1'b0;
      if (k == poke_edge) begin
        repeat (4) @(negedge clk);
        tx_data = 8'($urandom);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
      end
      if (k == reset_edge) begin
        repeat (4) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        tb_check("rst_async_c_oe", ps2c_oe, 0);
        tb_check("rst_async_d_oe", ps2d_oe, 0);
        tb_check("rst_async_busy", busy, 0);
        dev_c = 1'b1;
        dev_d = 1'b1;
        return;
      end
      repeat (HP) @(negedge clk);
      dev_c = 1'b1;
      repeat (HP / 2) @(negedge clk);
      if (k <= 10) got[k-1] = ps2d_in;
      if (k == 10 && ack) dev_d = 1'b0;
      repeat (HP / 2) @(negedge clk);
    end
    dev_d = 1'b1;
    ok = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit ack, input int poke_edge, input string nm);
    logic [9:0] got;
    bit ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    pulse_start(d);
    run_device(ack, poke_edge, 0, got, ok);
    repeat (20) @(negedge clk);
    tb_check({nm, "_completed"}, ok, 1);
    tb_check({nm, "_frame"}, got, exp_frame(d));
    tb_check({nm, "_parity"}, got[8], exp_frame(d) >> 8 & 1);
    tb_check({nm, "_inhibit_len"}, inh_len, INH);
    tb_check({nm, "_done_cnt"}, done_cnt - d0, ack ? 1 : 0);
    tb_check({nm, "_err_cnt"}, err_cnt - e0, ack ? 0 : 1);
    tb_check({nm, "_busy_idle"}, busy, 0);
    tb_check({nm, "_oe_idle"}, {ps2c_oe, ps2d_oe}, 0);
  endtask

  initial begin
    logic [9:0] got;
    bit ok, seen;
    int d0, e0, t;

    #1;
    tb_check("reset_c_oe", ps2c_oe, 0);
    tb_check("reset_d_oe", ps2d_oe, 0);
    tb_check("reset_busy", busy, 0);
    tb_check("reset_done", done, 0);
    tb_check("reset_error", error, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    send_frame(8'hED, 1'b1, 0, "ed_ack");
    send_frame(8'hF4, 1'b1, 0, "f4_ack");
    send_frame(8'($urandom), 1'b0, 0, "no_ack");
    tb_check("no_ack_busy_at_error", busy_on_err, 0);

    // Device never clocks after request-to-send.
    e0 = err_cnt;
    d0 = done_cnt;
    pulse_start(8'($urandom));
    wait_rts(seen);
    t = 0;
    while (!error && t < int'(TMO) + 50) begin
      @(negedge clk);
      t++;
    end
    tb_check("timeout_latency_ok", (t >= int'(TMO) && t <= int'(TMO) + 1), 1);
    tb_check("timeout_oe", {ps2c_oe, ps2d_oe}, 0);
    repeat (5) @(negedge clk);
    tb_check("timeout_err_cnt", err_cnt - e0, 1);
    tb_check("timeout_done_cnt", done_cnt - d0, 0);
    tb_check("timeout_busy", busy, 0);

    send_frame(8'($urandom), 1'b1, 5, "restart_ignored");

    // Asynchronous reset in the middle of the data bits.
    d0 = done_cnt;
    e0 = err_cnt;
    pulse_start(8'($urandom));
    run_device(1'b1, 0, 6, got, ok);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    tb_check("rst_mid_no_done", done_cnt - d0, 0);
    tb_check("rst_mid_no_err", err_cnt - e0, 0);
    tb_check("rst_mid_oe", {ps2c_oe, ps2d_oe}, 0);
    send_frame(8'($urandom), 1'b1, 0, "after_reset");

    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'($urandom_range(0, 1)), 0, "random");

    tb_check("done_error_exclusive", both_cnt, 0);
    tb_check("busy_low_on_error", busy_on_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
